// File: rtl/avalon_gpio_pkg.sv
// Shared register map and edge-type encodings for the Avalon-MM GPIO PIO.
package avalon_gpio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/gpio_in_sync.sv
// Input synchroniser chain, one-sample history register and per-bit edge detector.
module gpio_in_sync
    import avalon_gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] edge_det
);

    logic [WIDTH-1:0]     sync_p [SYNC_STAGES];
    logic [WIDTH-1:0]     prev;
    logic [SYNC_STAGES:0] vld_p;
    logic [WIDTH-1:0]     raw_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
            prev  <= '0;
            vld_p <= '0;
        end else begin
            sync_p[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
            prev  <= sync_p[SYNC_STAGES-1];
            vld_p <= {vld_p[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sync_in = sync_p[SYNC_STAGES-1];

    always_comb begin
        raw_edge = sync_in & ~prev;
        if (EDGE_TYPE == EDGE_FALL)     raw_edge = ~sync_in & prev;
        else if (EDGE_TYPE == EDGE_ANY) raw_edge = sync_in ^ prev;
    end

    // Edges count only once prev holds a real pin sample, so a pin held high
    // across reset is not mistaken for a rising edge after release.
    assign edge_det = vld_p[SYNC_STAGES] ? raw_edge : '0;

endmodule

// File: rtl/avalon_gpio_pio.sv
// Avalon-MM GPIO slave: per-bit direction, synchronised inputs, edge capture and level IRQ.
// Define AVALON_GPIO_SETCLR_EN to enable the OUTSET/OUTCLEAR atomic output registers.
module avalon_gpio_pio
    import avalon_gpio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe
);

    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] cap_reg;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] rd_mux;
    logic [31:0]      rd_word;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign rd_en        = chipselect & ~read_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;
    assign clr_mask     = (wr_en && address == ADDR_EDGE) ? wdata : '0;

    gpio_in_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_in_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .sync_in  (sync_in),
        .edge_det (edge_det)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= RESET_OUT;
            oe       <= RESET_DIR;
            irq_mask <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:    out_port <= wdata;
                ADDR_DIR:     oe       <= wdata;
                ADDR_IRQMASK: irq_mask <= wdata;
`ifdef AVALON_GPIO_SETCLR_EN
                ADDR_OUTSET:  out_port <= out_port | wdata;
                ADDR_OUTCLR:  out_port <= out_port & ~wdata;
`endif
                default: ;
            endcase
        end
    end

    // A fresh edge wins over a write-1-clear landing on the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_reg <= '0;
            irq     <= 1'b0;
        end else begin
            cap_reg <= (cap_reg & ~clr_mask) | edge_det;
            irq     <= |(cap_reg & irq_mask);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux = (sync_in & ~oe) | (out_port & oe);
            ADDR_DIR:     rd_mux = oe;
            ADDR_IRQMASK: rd_mux = irq_mask;
            ADDR_EDGE:    rd_mux = cap_reg;
            default:      rd_mux = '0;
        endcase
        rd_word = '0;
        rd_word[WIDTH-1:0] = rd_mux;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   readdata <= '0;
        else if (rd_en) readdata <= rd_word;
    end

endmodule

// File: tb/tb_avalon_gpio_pio.sv
// Directed bench for avalon_gpio_pio (WIDTH=8, RESET_OUT=8'hA5, rising-edge capture, 2-stage sync).
module tb_avalon_gpio_pio;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic        read_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;
    logic [7:0]  in_port = '0;
    logic [7:0]  out_port;
    logic [7:0]  oe;

    int total = 0;
    int bad   = 0;

`ifdef AVALON_GPIO_SETCLR_EN
    localparam logic [7:0] EXP_SET = 8'h3F;
    localparam logic [7:0] EXP_CLR = 8'h3A;
`else
    localparam logic [7:0] EXP_SET = 8'h0F;
    localparam logic [7:0] EXP_CLR = 8'h0F;
`endif

    avalon_gpio_pio #(
        .WIDTH       (8),
        .RESET_OUT   (8'hA5),
        .RESET_DIR   (8'h00),
        .EDGE_TYPE   (0),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe         (oe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        tick();
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        ticks(3);
        check("rst_out_port", {24'h0, out_port}, 32'hA5);
        check("rst_oe", {24'h0, oe}, 32'h00);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_readdata", readdata, 32'h0);
        reset_n = 1'b1;
        tick();
        rd(3'd3);
        check("rst_edge_read", readdata, 32'h0);

        // Direction and data mux
        in_port = 8'hF0;
        wr(3'd1, 32'h0000_000F);
        wr(3'd0, 32'hFFFF_FF3C);
        check("data_out_port", {24'h0, out_port}, 32'h3C);
        check("dir_oe", {24'h0, oe}, 32'h0F);
        ticks(2);
        rd(3'd0);
        check("data_read_mix", readdata, 32'h0000_00FC);
        tick();
        check("readdata_hold", readdata, 32'h0000_00FC);
        rd(3'd1);
        check("dir_read", readdata, 32'h0000_000F);
        rd(3'd3);
        check("edge_f0_capture", readdata, 32'h0000_00F0);
        wr(3'd3, 32'h0000_00FF);
        rd(3'd3);
        check("edge_clear_all", readdata, 32'h0);

        // Rising edge on bit 0 with mask: latency, pre-update read, irq timing
        wr(3'd2, 32'h0000_0001);
        in_port = 8'hF1;
        tick();
        rd(3'd3);
        check("edge_lat_p2", readdata, 32'h0);
        rd(3'd3);
        check("edge_read_pre_update", readdata, 32'h0);
        check("irq_before_capture", {31'h0, irq}, 32'h0);
        rd(3'd3);
        check("edge_bit0_set", readdata, 32'h0000_0001);
        check("irq_assert", {31'h0, irq}, 32'h1);
        wr(3'd3, 32'h0000_0001);
        check("irq_lag_after_clear", {31'h0, irq}, 32'h1);
        tick();
        check("irq_deassert_clear", {31'h0, irq}, 32'h0);

        // Clear-vs-set collision on bit 2
        in_port = 8'hF5;
        ticks(2);
        wr(3'd3, 32'h0000_0004);
        rd(3'd3);
        check("collision_set_wins", readdata, 32'h0000_0004);
        wr(3'd3, 32'h0000_0004);
        rd(3'd3);
        check("clear_bit2", readdata, 32'h0);

        // Falling edge is not captured in rising mode
        in_port = 8'hF1;
        ticks(4);
        rd(3'd3);
        check("no_fall_capture", readdata, 32'h0);

        // Mask removal drops irq but keeps the capture
        in_port = 8'hF0;
        ticks(4);
        in_port = 8'hF1;
        ticks(5);
        check("irq_reassert", {31'h0, irq}, 32'h1);
        wr(3'd2, 32'h0);
        tick();
        check("irq_mask_off", {31'h0, irq}, 32'h0);
        rd(3'd3);
        check("capture_kept", readdata, 32'h0000_0001);
        wr(3'd3, 32'h0000_0001);

        // Set/clear registers and reserved addresses
        wr(3'd0, 32'h0000_000F);
        wr(3'd4, 32'h0000_0030);
        check("outset", {24'h0, out_port}, {24'h0, EXP_SET});
        wr(3'd5, 32'h0000_0005);
        check("outclr", {24'h0, out_port}, {24'h0, EXP_CLR});
        rd(3'd4);
        check("outset_read_zero", readdata, 32'h0);
        wr(3'd6, 32'hFFFF_FFFF);
        check("reserved_write", {24'h0, out_port}, {24'h0, EXP_CLR});
        rd(3'd6);
        check("reserved_read", readdata, 32'h0);

        // Reset mid-operation
        wr(3'd2, 32'h0000_00FF);
        in_port = 8'h00;
        ticks(4);
        wr(3'd3, 32'h0000_00FF);
        in_port = 8'hFF;
        ticks(5);
        check("pre_reset_irq", {31'h0, irq}, 32'h1);
        rd(3'd3);
        check("pre_reset_edge", readdata, 32'h0000_00FF);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_irq", {31'h0, irq}, 32'h0);
        check("async_rst_edge", {24'h0, dut.cap_reg}, 32'h0);
        check("async_rst_out", {24'h0, out_port}, 32'hA5);
        check("async_rst_readdata", readdata, 32'h0);
        tick();
        reset_n = 1'b1;
        wr(3'd2, 32'h0000_00FF);
        ticks(8);
        rd(3'd3);
        check("no_edge_after_release", readdata, 32'h0);
        check("no_irq_after_release", {31'h0, irq}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avalon_gpio_pio.md
Name: avalon_gpio_pio

Overview:
- Parametrised Avalon-MM general-purpose I/O slave; next generation of the single-bit output PIO.
- Adds:
  - N-bit bidirectional pins with per-bit direction.
  - Synchronised input sampling.
  - Edge capture with interrupt mask and level IRQ.
- Sits on the lightweight HPS-to-FPGA bus next to other soc_design PIOs; drives board LEDs/keys/GPIO headers.

Parameters:
- WIDTH, 8, number of GPIO bits (1..32).
- RESET_OUT, 0, reset value of the output data register (WIDTH bits).
- RESET_DIR, 0, reset value of the direction register (1 = output).
- EDGE_TYPE, 0, edge to capture: 0 rising, 1 falling, 2 any.
- SYNC_STAGES, 2, input synchroniser depth (2..4).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- address  in  3  word register index.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- read_n  in  1  active-low read strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, registered.
- irq  out  1  level interrupt, active-high.
- in_port  in  WIDTH  asynchronous pin inputs.
- out_port  out  WIDTH  output data register.
- oe  out  WIDTH  per-bit output enable (the direction register).

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk.
- Outputs and state at reset:
  - out_port=RESET_OUT, oe=RESET_DIR.
  - irqmask=0, edgecapture=0, readdata=0, irq=0.
  - All synchroniser stages and the edge-detect history register = 0.
- Write = chipselect & ~write_n; read = chipselect & ~read_n. Both single-cycle, no waitrequest.
- Register map:
  - 0 DATA: read returns synced inputs for bits with oe=0 and out_port for bits with oe=1. Write loads out_port.
  - 1 DIRECTION: R/W.
  - 2 IRQMASK: R/W.
  - 3 EDGECAPTURE: read returns captures. Writing 1 to a bit clears it; writing 0 has no effect.
  - 4 OUTSET, 5 OUTCLEAR: see Optional Feature.
  - 6, 7: reserved. Reads return 0; writes are ignored.
- Bits [31:WIDTH] read 0; writedata[31:WIDTH] is ignored.
- Read latency is 1 cycle: readdata is registered from the address of the read cycle. readdata holds its value when no read occurs.
- Input path:
  - in_port passes through a SYNC_STAGES flop chain to give sync_in.
  - A history register prev <= sync_in.
  - Edge per EDGE_TYPE: rising = sync_in & ~prev; falling = ~sync_in & prev; any = XOR.
  - Pin-to-capture latency = SYNC_STAGES+1 cycles.
  - Edges are detected on all bits regardless of oe.
- EDGECAPTURE update: next = (cur & ~clear_mask) | edge. If a new edge and a write-1-clear hit the same bit in the same cycle, the bit stays set (set wins).
- irq = |(edgecapture & irqmask), registered; asserts 1 cycle after the capture bit sets.
- Writing IRQMASK to 0 deasserts irq the following cycle; the capture bit is kept.
- A simultaneous read of EDGECAPTURE and an edge returns the pre-update value.
- Reset mid-operation: everything returns to reset values immediately. The first edge can be detected no earlier than SYNC_STAGES+1 cycles after release.

Optional Feature:
- Macro: AVALON_GPIO_SETCLR_EN.
- Defined:
  - Write to 4 performs out_port |= writedata.
  - Write to 5 performs out_port &= ~writedata.
  - Atomic per-bit control without read-modify-write.
  - Reads of 4/5 return 0.
- Undefined: 4/5 behave as reserved; the logic is not compiled in.

Decomposition:
- Package avalon_gpio_pkg holds:
  - register address localparams: ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGE=3, ADDR_OUTSET=4, ADDR_OUTCLR=5.
  - edge-type constants: EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- Sub-module gpio_in_sync: parameters WIDTH, SYNC_STAGES, EDGE_TYPE. Contains the synchroniser chain, history register and edge vector. Outputs sync_in and edge.

Test Plan:
- Reset, WIDTH=8, RESET_OUT=8'hA5: out_port=8'hA5, oe=0, irq=0, read addr 3 -> 0.
- Write DIR=8'h0F, DATA=8'h3C; in_port=8'hF0 -> out_port=8'h3C. Read DATA one cycle later -> 32'h000000FC.
- EDGE_TYPE=0, IRQMASK=8'h01, in_port[0] 0->1:
  - edgecapture[0]=1 after 3 cycles; irq=1 one cycle later.
  - Write addr 3 = 8'h01 -> irq=0 next cycle.
- Clear-vs-set collision: write 1 to addr 3 bit 2 in the same cycle as bit 2 edge is detected -> bit 2 remains 1.
- AVALON_GPIO_SETCLR_EN with DATA=8'h0F:
  - write addr 4=8'h30 -> out_port=8'h3F.
  - write addr 5=8'h05 -> out_port=8'h3A.
  - Macro off: same writes leave out_port=8'h0F.
- Assert reset_n low while edgecapture=8'hFF and irq=1: edgecapture and irq clear immediately. After release, in_port held high produces no rising edge.
